reg_bank_reader: RTL and testbench

REG_BANK_READER -- requirements
Module: reg_bank_reader

---
 rtl/reg_bank_reader.sv | 115 +++++++++++
 tb/tb_reg_bank_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_reader.sv
// Register bank with a registered two-operand read port.
// A read snapshots rs/rt, with write-through bypass, and holds the result until the consumer takes it.
module reg_bank_reader #(
    parameter logic [31:0] SP_RESET = 32'd227,
    parameter logic [31:0] RA_RESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_req,
    input  logic [31:0] instr,
    input  logic        rd_taken,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic        rd_valid,
    output logic        busy
);

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 32;
    localparam int unsigned SP_IDX = 29;
    localparam int unsigned RA_IDX = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        HOLD    = 2'b10
    } state_t;

    logic [DW-1:0] regs [NREGS];

    state_t        state_q, state_d;
    logic [AW-1:0] rs_q, rs_d;
    logic [AW-1:0] rt_q, rt_d;
    logic [DW-1:0] a_d, b_d;
    logic [DW-1:0] a_src, b_src;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:26], instr[15:0]};

    // Operand source: $0 is hard zero, a same-cycle write wins over the array.
    assign a_src = (rs_q == '0) ? '0 :
                   (wr_en && (wr_addr == rs_q)) ? wr_data : regs[rs_q];
    assign b_src = (rt_q == '0) ? '0 :
                   (wr_en && (wr_addr == rt_q)) ? wr_data : regs[rt_q];

    // Register file; writes are accepted in every FSM state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (i == SP_IDX) begin
                    regs[i] <= SP_RESET;
                end else if (i == RA_IDX) begin
                    regs[i] <= RA_RESET;
                end else begin
                    regs[i] <= '0;
                end
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rs_q     <= '0;
            rt_q     <= '0;
            a_out    <= '0;
            b_out    <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            a_out    <= a_d;
            b_out    <= b_d;
            rd_valid <= (state_d == HOLD);
            busy     <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        a_d     = a_out;
        b_d     = b_out;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    rs_d    = instr[25:21];
                    rt_d    = instr[20:16];
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                a_d     = a_src;
                b_d     = b_src;
                state_d = HOLD;
            end
            HOLD: begin
                if (rd_taken) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed self-checking bench for reg_bank_reader.
module tb_reg_bank_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [31:0] instr;
    logic        rd_taken;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic        rd_valid;
    logic        busy;

    int tests = 0;
    int fails = 0;

    reg_bank_reader dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .instr    (instr),
        .rd_taken (rd_taken),
        .a_out    (a_out),
        .b_out    (b_out),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, 16'h0};
    endfunction

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_regs(input logic [4:0] rs, input logic [4:0] rt,
                             output logic [31:0] a, output logic [31:0] b, output logic v);
        instr = mk_instr(rs, rt); rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        a = a_out; b = b_out; v = rd_valid;
        rd_taken = 1'b1;
        tick();
        rd_taken = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] a, b; logic v;
        reset = 1'b0;
        tick(); tick();
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (a_out !== 32'd0) begin fails++; $display("FAIL reset_a: got %h want 0", a_out); end
        tests++; if (b_out !== 32'd0) begin fails++; $display("FAIL reset_b: got %h want 0", b_out); end
        reset = 1'b1;
        read_regs(5'd31, 5'd1, a, b, v);
        tests++; if (a !== 32'd0) begin fails++; $display("FAIL reset_ra: got %h want 0", a); end
        tests++; if (b !== 32'd0) begin fails++; $display("FAIL reset_r1: got %h want 0", b); end
    endtask

    task automatic test_sp_read();
        instr = mk_instr(5'd29, 5'd0); rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL capture_valid: got %b want 0", rd_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL capture_busy: got %b want 1", busy); end
        tick();
        tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL latency_valid: got %b want 1", rd_valid); end
        tests++; if (a_out !== 32'd227) begin fails++; $display("FAIL sp_a: got %h want %h", a_out, 32'd227); end
        tests++; if (b_out !== 32'd0) begin fails++; $display("FAIL sp_b: got %h want 0", b_out); end
        rd_taken = 1'b1;
        tick();
        rd_taken = 1'b0;
        tests++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL taken_idle: got valid=%b busy=%b want 0 0", rd_valid, busy); end
        tests++; if (a_out !== 32'd227) begin fails++; $display("FAIL idle_retain: got %h want %h", a_out, 32'd227); end
    endtask

    task automatic test_write_read();
        logic [31:0] a, b; logic v;
        do_write(5'd8, 32'hDEADBEEF);
        read_regs(5'd8, 5'd8, a, b, v);
        tests++; if (v !== 1'b1) begin fails++; $display("FAIL r8_valid: got %b want 1", v); end
        tests++; if (a !== 32'hDEADBEEF) begin fails++; $display("FAIL r8_a: got %h want deadbeef", a); end
        tests++; if (b !== 32'hDEADBEEF) begin fails++; $display("FAIL r8_b: got %h want deadbeef", b); end
        do_write(5'd0, 32'h1234);
        read_regs(5'd0, 5'd0, a, b, v);
        tests++; if (a !== 32'd0 || b !== 32'd0) begin fails++; $display("FAIL r0: got %h %h want 0 0", a, b); end
    endtask

    task automatic test_bypass();
        logic [31:0] a, b; logic v;
        // Write during CAPTURE is forwarded; instr change after latching is ignored.
        instr = mk_instr(5'd5, 5'd9); rd_req = 1'b1;
        tick();
        rd_req = 1'b0; instr = mk_instr(5'd8, 5'd8);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11;
        tick();
        wr_en = 1'b0;
        tests++; if (a_out !== 32'h11) begin fails++; $display("FAIL bypass_a: got %h want 11", a_out); end
        tests++; if (b_out !== 32'd0) begin fails++; $display("FAIL bypass_b: got %h want 0", b_out); end
        rd_taken = 1'b1; tick(); rd_taken = 1'b0;
        // Same-cycle write to the rt source forwards to b_out.
        instr = mk_instr(5'd0, 5'd9); rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_0009;
        tick();
        wr_en = 1'b0;
        tests++; if (b_out !== 32'hA5A5_0009) begin fails++; $display("FAIL bypass_rt: got %h want a5a50009", b_out); end
        rd_taken = 1'b1; tick(); rd_taken = 1'b0;
        // Write to $0 during CAPTURE is not forwarded.
        instr = mk_instr(5'd0, 5'd0); rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_en = 1'b0;
        tests++; if (a_out !== 32'd0) begin fails++; $display("FAIL bypass_r0: got %h want 0", a_out); end
        rd_taken = 1'b1; tick(); rd_taken = 1'b0;
        // Write during HOLD leaves the snapshot alone but lands in the array.
        instr = mk_instr(5'd7, 5'd7); rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        do_write(5'd7, 32'h11);
        tests++; if (a_out !== 32'd0 || rd_valid !== 1'b1) begin fails++; $display("FAIL hold_snapshot: got a=%h valid=%b want 0 1", a_out, rd_valid); end
        rd_taken = 1'b1; tick(); rd_taken = 1'b0;
        read_regs(5'd7, 5'd5, a, b, v);
        tests++; if (a !== 32'h11 || b !== 32'h11) begin fails++; $display("FAIL hold_later: got %h %h want 11 11", a, b); end
    endtask

    task automatic test_hold_stable();
        instr = mk_instr(5'd8, 5'd29); rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                rd_req = 1'b1; instr = mk_instr(5'd0, 5'd0);
            end
            tick();
            rd_req = 1'b0;
            tests++;
            if (rd_valid !== 1'b1 || busy !== 1'b1 || a_out !== 32'hDEADBEEF || b_out !== 32'd227) begin
                fails++;
                $display("FAIL hold_stable[%0d]: got v=%b busy=%b a=%h b=%h want 1 1 deadbeef e3", i, rd_valid, busy, a_out, b_out);
            end
        end
        rd_taken = 1'b1;
        tick();
        rd_taken = 1'b0;
        tests++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL hold_release: got v=%b busy=%b want 0 0", rd_valid, busy); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL req_not_queued: got busy=%b want 0", busy); end
    endtask

    task automatic test_taken_ignored();
        instr = mk_instr(5'd8, 5'd5); rd_req = 1'b1; rd_taken = 1'b1;
        tick();
        rd_req = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL taken_in_idle: got busy=%b want 1", busy); end
        tick();
        tests++; if (rd_valid !== 1'b1 || a_out !== 32'hDEADBEEF || b_out !== 32'h11) begin fails++; $display("FAIL taken_in_capture: got v=%b a=%h b=%h want 1 deadbeef 11", rd_valid, a_out, b_out); end
        tick();
        rd_taken = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL taken_in_hold: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b; logic v;
        read_regs(5'd29, 5'd8, a, b, v);
        tests++; if (a !== 32'd227 || b !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_first: got %h %h want e3 deadbeef", a, b); end
        read_regs(5'd8, 5'd29, a, b, v);
        tests++; if (v !== 1'b1 || a !== 32'hDEADBEEF || b !== 32'd227) begin fails++; $display("FAIL b2b_second: got v=%b %h %h want 1 deadbeef e3", v, a, b); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] a, b; logic v;
        do_write(5'd8, 32'hCAFE0001);
        instr = mk_instr(5'd8, 5'd8); rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tests++; if (a_out !== 32'hCAFE0001) begin fails++; $display("FAIL abort_pre: got %h want cafe0001", a_out); end
        reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hFFFF_FFFF; rd_req = 1'b1; rd_taken = 1'b1;
        tick();
        tests++; if (rd_valid !== 1'b0 || busy !== 1'b0 || a_out !== 32'd0 || b_out !== 32'd0) begin fails++; $display("FAIL abort_outputs: got v=%b busy=%b a=%h b=%h want 0 0 0 0", rd_valid, busy, a_out, b_out); end
        reset = 1'b1; wr_en = 1'b0; rd_req = 1'b0; rd_taken = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got busy=%b want 0", busy); end
        read_regs(5'd8, 5'd29, a, b, v);
        tests++; if (a !== 32'd0) begin fails++; $display("FAIL abort_r8: got %h want 0", a); end
        tests++; if (b !== 32'd227) begin fails++; $display("FAIL abort_sp: got %h want e3", b); end
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; instr = '0; rd_taken = 1'b0;
        #1;
        test_reset();
        test_sp_read();
        test_write_read();
        test_bypass();
        test_hold_stable();
        test_taken_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
